// File: rtl/lease_tracker_fa.sv
// rtl/lease_tracker_fa.sv - per-line lease counters with a multi-lane victim scan FSM.
// Optional LEASE_TRACKER_MULTI_EXPIRED_EN adds the expired-line population count and multi flag.
module lease_tracker_fa #(
  parameter int CACHE_BLOCK_CAPACITY = 128,
  parameter int BW_LEASE             = 16,
  parameter int SCAN_LANES           = 8,
  localparam int BW_LINE             = $clog2(CACHE_BLOCK_CAPACITY)
) (
  input  logic                clock_i,
  input  logic                resetn_i,
  input  logic                enable_i,
  input  logic                ref_req_i,
  input  logic [BW_LINE-1:0]  ref_line_i,
  input  logic [BW_LEASE-1:0] ref_lease_i,
  input  logic                victim_req_i,
  output logic                busy_o,
  output logic                victim_done_o,
  output logic [BW_LINE-1:0]  victim_line_o,
  output logic                victim_expired_o,
  output logic                flag_expired_multi_o
);

  localparam int CAP    = CACHE_BLOCK_CAPACITY;
  localparam int NWIN   = CAP / SCAN_LANES;
  localparam int BW_WIN = (NWIN > 1) ? $clog2(NWIN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BW_LEASE-1:0] lease_q [CAP];
  logic [BW_LEASE-1:0] lease_d [CAP];
  logic [BW_WIN-1:0]   win_q, win_d;
  logic [BW_LINE-1:0]  start_q, start_d;
  logic [BW_LINE-1:0]  ptr_q, ptr_d;
  logic [BW_LINE-1:0]  vline_q, vline_d;
  logic                vexp_q, vexp_d;
  logic                ref_fire;
  logic [BW_LINE-1:0]  base;
  logic [BW_LINE-1:0]  lane;
  logic                hit;
  logic [BW_LINE-1:0]  hit_line;
  logic                last_win;
  logic                scan_end;

  assign ref_fire = enable_i & ref_req_i;

  // Referenced line reloads; every other live counter ages by one and saturates at zero.
  always_comb begin
    for (int j = 0; j < CAP; j++) begin
      lease_d[j] = lease_q[j];
      if (ref_fire) begin
        if (ref_line_i == BW_LINE'(j)) begin
          lease_d[j] = ref_lease_i;
        end else if (lease_q[j] != '0) begin
          lease_d[j] = lease_q[j] - BW_LEASE'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int j = 0; j < CAP; j++) begin
        lease_q[j] <= '0;
      end
    end else if (enable_i) begin
      lease_q <= lease_d;
    end
  end

  // Window lanes are walked high-to-low so the lowest expired lane wins.
  always_comb begin
    base     = start_q + BW_LINE'(win_q * SCAN_LANES);
    lane     = '0;
    hit      = 1'b0;
    hit_line = '0;
    for (int i = SCAN_LANES - 1; i >= 0; i--) begin
      lane = base + BW_LINE'(i);
      if (lease_q[lane] == '0) begin
        hit      = 1'b1;
        hit_line = lane;
      end
    end
  end

  assign last_win = (win_q == BW_WIN'(NWIN - 1));
  assign scan_end = (state_q == SCAN) & (hit | last_win);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    start_d = start_q;
    ptr_d   = ptr_q;
    vline_d = vline_q;
    vexp_d  = vexp_q;
    if (enable_i) begin
      case (state_q)
        IDLE: begin
          if (victim_req_i) begin
            state_d = SCAN;
            start_d = ptr_q;
            win_d   = '0;
          end
        end
        SCAN: begin
          if (hit) begin
            vline_d = hit_line;
            vexp_d  = 1'b1;
            state_d = DONE;
          end else if (last_win) begin
            vline_d = start_q;
            vexp_d  = 1'b0;
            state_d = DONE;
          end else begin
            win_d = win_q + BW_WIN'(1);
          end
        end
        DONE: begin
          ptr_d   = vline_q + BW_LINE'(1);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      win_q   <= '0;
      start_q <= '0;
      ptr_q   <= '0;
      vline_q <= '0;
      vexp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      start_q <= start_d;
      ptr_q   <= ptr_d;
      vline_q <= vline_d;
      vexp_q  <= vexp_d;
    end
  end

  assign busy_o           = (state_q == SCAN);
  assign victim_done_o    = (state_q == DONE);
  assign victim_line_o    = vline_q;
  assign victim_expired_o = vexp_q;

`ifdef LEASE_TRACKER_MULTI_EXPIRED_EN
  logic [BW_LINE:0] cnt_q, cnt_d;
  logic             multi_q;

  // Count is taken from the next-state leases so it always matches the live counters.
  always_comb begin
    cnt_d = '0;
    for (int j = 0; j < CAP; j++) begin
      if (lease_d[j] == '0) begin
        cnt_d = cnt_d + (BW_LINE + 1)'(1);
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q   <= (BW_LINE + 1)'(CAP);
      multi_q <= 1'b0;
    end else if (enable_i) begin
      cnt_q <= cnt_d;
      if (scan_end) begin
        multi_q <= (cnt_q >= (BW_LINE + 1)'(2));
      end
    end
  end

  assign flag_expired_multi_o = victim_done_o & multi_q;
`else
  logic unused_scan_end;
  assign unused_scan_end      = scan_end;
  assign flag_expired_multi_o = 1'b0;
`endif

endmodule
